serial_adder: RTL
=================

# serial_adder

Parametrised bit-serial adder built around a single full-adder cell and a registered carry. It adds two WIDTH-bit operands LSB-first, one bit per clock, under a start/busy/done handshake, and reports sum, carry-out and signed overflow. It is the area-optimised arithmetic unit for datapaths where one cell plus a counter is cheaper than a WIDTH-bit ripple chain and multi-cycle latency is acceptable.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- cin  in  1  carry-in; captured when start is accepted.
- sub  in  1  subtract select; captured when start is accepted. Present only with SERIAL_ADDER_SUB_EN.
- busy  out  1  high while bits are being processed (RUN).
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  registered result.
- carryOut  out  1  registered carry out of the MSB.
- overflow  out  1  registered two's-complement overflow.

## Operation
- States: IDLE, RUN, DONE. Reset state: IDLE.
- IDLE:
  - On start=1, load a and b into shift registers and load carry register c with cin.
  - Clear the bit counter (clog2(WIDTH) bits) and go to RUN.
  - On start=0, stay in IDLE.
- RUN, each edge:
  - s = a0 ^ b0 ^ c.
  - c <= majority(a0, b0, c).
  - Shift the result register right, inserting s at the MSB.
  - Shift the operand registers right and increment the counter.
- On the edge that processes bit WIDTH-1:
  - Load sum with the final result.
  - Load carryOut with the carry out of the MSB.
  - Load overflow with (carry into MSB) XOR (carry out of MSB).
  - Go to DONE.
- DONE: done=1 for this cycle only; unconditional transition to IDLE on the next edge.
- start is ignored in RUN and DONE; it is not queued. Operand inputs may change freely after acceptance.
- sum, carryOut and overflow change only on entry to DONE and hold until the next completion.
- Arithmetic is modulo 2^WIDTH.
- No cancel or abort exists; only rst stops an operation.

## Timing
- Reset values: busy=0, done=0, sum=0, carryOut=0, overflow=0. Internal state: IDLE, counter=0, c=0.
- rst asserted mid-RUN: all of the above take effect immediately (asynchronous). The in-flight operation is lost and no done is produced.
- Let edge k be the edge that samples start=1 in IDLE:
  - busy is high after edge k through edge k+WIDTH-1.
  - The outputs are updated and done goes high at edge k+WIDTH.
  - done falls at edge k+WIDTH+1.
- The earliest next acceptance is edge k+WIDTH+2, so throughput is one operation per WIDTH+2 cycles.
- busy and done are never high together.
- All outputs are registered. No combinational path exists from any input to any output.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists.
  - With sub=1, the captured b is inverted and c is initialised to 1, giving a - b; cin is ignored.
  - carryOut=1 means no borrow (a >= b unsigned). overflow is the signed subtraction overflow.
  - sub=0 behaves exactly as the undefined case.
- SERIAL_ADDER_SUB_EN undefined: the sub port and its logic are absent, and the block performs addition only.

## Test plan
WIDTH=8 for all scenarios.
- a=0x0F, b=0x01, cin=0, start pulsed -> sum=0x10, carryOut=0, overflow=0. done exactly 8 edges after the start edge; busy high for 8 cycles.
- a=0xFF, b=0x01, cin=1 -> sum=0x01, carryOut=1, overflow=0.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, carryOut=0, overflow=1. Then a=0x80, b=0x80 -> sum=0x00, carryOut=1, overflow=1.
- start held high continuously, with a and b changed every cycle during RUN:
  - The first result reflects only the operands captured at acceptance.
  - Back-to-back acceptances are exactly 10 edges apart.
  - sum holds between done pulses.
- rst asserted asynchronously after 3 bits of a=0x55, b=0x33:
  - busy, done and sum go to 0 without a clock edge, and no done pulse appears.
  - A following a=0x55, b=0x33 yields sum=0x88, carryOut=0, overflow=1.
- With SERIAL_ADDER_SUB_EN:
  - a=0x05, b=0x07, sub=1 -> sum=0xFE, carryOut=0, overflow=0.
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, carryOut=1, overflow=1.
  - cin=1 with sub=1 has no effect.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built from one full-adder cell and a
// registered carry. The two operands are processed LSB-first, one bit per
// clock, under a start/busy/done handshake. The block reports sum, carry-out
// and two's-complement overflow.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add the `sub` port. With
// sub=1 the captured b is inverted and the carry is seeded with 1, so the
// block computes a - b and ignores cin.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   start     in   request; sampled only while idle
//   a, b      in   WIDTH-bit operands; captured when start is accepted
//   cin       in   carry-in; captured when start is accepted
//   sub       in   subtract select (SERIAL_ADDER_SUB_EN only)
//   busy      out  high while bits are being processed
//   done      out  one-cycle pulse; result outputs are valid
//   sum       out  registered WIDTH-bit result
//   carryOut  out  registered carry out of the MSB
//   overflow  out  registered signed overflow
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // The single full-adder cell.
  logic s_bit;
  logic c_next;
  assign s_bit  = a_q[0] ^ b_q[0] ^ c_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
`ifdef SERIAL_ADDER_SUB_EN
          // Subtraction as a + ~b + 1.
          if (sub) begin
            b_d = ~b;
            c_d = 1'b1;
          end
`endif
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        c_d   = c_next;
        acc_d = {s_bit, acc_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // c_q is the carry into the MSB here, c_next the carry out of it.
          sum_d   = {s_bit, acc_q[WIDTH-1:1]};
          cout_d  = c_next;
          ovf_d   = c_q ^ c_next;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign carryOut = cout_q;
  assign overflow = ovf_q;

endmodule
